// File: rtl/hazard_unit_if.sv
// Decode/MEM-WB/interrupt inputs and pipeline-control outputs of the hazard unit.
// Combinational bundle, no latency; stalls are the only backpressure it carries.
interface hazard_unit_if #(
    parameter int NUM_IRQ = 8
);
    logic               stall_fetch_req;
    logic               stall_decode_req;
    logic               halt;
    logic               take_branch_target;
    logic               illegal_opcode_exception;
    logic               return_in_pipeline;
    logic [7:0]         mem_wb_opcode;
    logic               mem_wb_reti_bit;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_enable;
    logic               global_int_en;

    logic               stall_fetch;
    logic               stall_decode;
    logic [3:0]         hazard_prog_cntr_sel;
    logic               inst_word_sel;
    logic [31:0]        hazard_inst_word;
    logic [13:0]        prog_cntr_int_addr;
    logic               in_isr;
    logic [NUM_IRQ-1:0] int_ack;

    // Datapath / decode side
    modport master (
        output stall_fetch_req, stall_decode_req, halt, take_branch_target,
               illegal_opcode_exception, return_in_pipeline, mem_wb_opcode,
               mem_wb_reti_bit, irq, irq_enable, global_int_en,
        input  stall_fetch, stall_decode, hazard_prog_cntr_sel, inst_word_sel,
               hazard_inst_word, prog_cntr_int_addr, in_isr, int_ack
    );

    // Hazard unit side
    modport slave (
        input  stall_fetch_req, stall_decode_req, halt, take_branch_target,
               illegal_opcode_exception, return_in_pipeline, mem_wb_opcode,
               mem_wb_reti_bit, irq, irq_enable, global_int_en,
        output stall_fetch, stall_decode, hazard_prog_cntr_sel, inst_word_sel,
               hazard_inst_word, prog_cntr_int_addr, in_isr, int_ack
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard control: stalls, PC source select, NOP/CALL injection, interrupt entry/exit.
// Mealy outputs: redirects/injections act in the same cycle; vector address and in_isr are registered.
// Backpressure: forwards decode stall requests, holds fetch during RET_WAIT and fetch+decode in HALTED.
module hazard_unit #(
    parameter int          NUM_IRQ       = 8,
    parameter logic [13:0] VECTOR_BASE   = 14'h0004,
    parameter int          VECTOR_STRIDE = 2,
    parameter logic [13:0] EXC_VECTOR    = 14'h0002,
    parameter logic [31:0] NOP_WORD      = 32'h0000_0000,
    parameter logic [31:0] INT_CALL_WORD = 32'h0000_0041,
    parameter logic [7:0]  RET_OPCODE    = 8'h42
) (
    input  logic         clock,
    input  logic         reset,
    hazard_unit_if.slave hu
);

    localparam logic [3:0] PC_INC    = 4'd0;
    localparam logic [3:0] PC_BRANCH = 4'd1;
    localparam logic [3:0] PC_INT    = 4'd2;
    localparam logic [3:0] PC_RET    = 4'd3;
    localparam logic [3:0] PC_HOLD   = 4'd4;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        INT_ENTER = 3'd1,
        EXC_ENTER = 3'd2,
        RET_WAIT  = 3'd3,
        HALTED    = 3'd4
    } state_t;

    state_t       state, state_nxt;
    logic         in_isr_q, in_isr_nxt;
    logic [13:0]  int_addr_q, int_addr_nxt;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_onehot;
    logic [13:0]        irq_vec;
    logic               irq_found;
    logic               irq_ok;
    logic               take_irq;

    assign pending = hu.irq & hu.irq_enable;
    assign irq_ok  = irq_found && hu.global_int_en;

    // Lowest index wins; vector address wraps in 14 bits.
    always_comb begin
        irq_found  = 1'b0;
        irq_onehot = '0;
        irq_vec    = VECTOR_BASE;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!irq_found && pending[i]) begin
                irq_found     = 1'b1;
                irq_onehot[i] = 1'b1;
                irq_vec       = VECTOR_BASE + 14'(i * VECTOR_STRIDE);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RUN;
            in_isr_q   <= 1'b0;
            int_addr_q <= '0;
        end else begin
            state      <= state_nxt;
            in_isr_q   <= in_isr_nxt;
            int_addr_q <= int_addr_nxt;
        end
    end

    always_comb begin
        state_nxt               = state;
        in_isr_nxt              = in_isr_q;
        int_addr_nxt            = int_addr_q;
        take_irq                = 1'b0;
        hu.stall_fetch          = 1'b0;
        hu.stall_decode         = 1'b0;
        hu.hazard_prog_cntr_sel = PC_INC;
        hu.inst_word_sel        = 1'b0;
        hu.hazard_inst_word     = NOP_WORD;
        hu.int_ack              = '0;

        unique case (state)
            RUN: begin
                hu.stall_fetch          = hu.stall_fetch_req;
                hu.stall_decode         = hu.stall_decode_req;
                hu.hazard_prog_cntr_sel = hu.stall_fetch_req ? PC_HOLD : PC_INC;
                if (hu.illegal_opcode_exception) begin
                    hu.inst_word_sel = 1'b1;
                    int_addr_nxt     = EXC_VECTOR;
                    state_nxt        = EXC_ENTER;
                end else if (hu.take_branch_target) begin
                    // Redirect and squash the wrong-path fetch in the same cycle
                    hu.hazard_prog_cntr_sel = PC_BRANCH;
                    hu.inst_word_sel        = 1'b1;
                end else if (hu.return_in_pipeline) begin
                    state_nxt = RET_WAIT;
                end else if (hu.halt) begin
                    state_nxt = HALTED;
                end else if (irq_ok && !in_isr_q &&
                             !hu.stall_fetch_req && !hu.stall_decode_req) begin
                    take_irq = 1'b1;
                end
            end
            INT_ENTER: begin
                hu.hazard_prog_cntr_sel = PC_INT;
                hu.inst_word_sel        = 1'b1;
                hu.hazard_inst_word     = INT_CALL_WORD;
                in_isr_nxt              = 1'b1;
                state_nxt               = RUN;
            end
            EXC_ENTER: begin
                // Exceptions nest: taken even if already in a service routine
                hu.hazard_prog_cntr_sel = PC_INT;
                in_isr_nxt              = 1'b1;
                state_nxt               = RUN;
            end
            RET_WAIT: begin
                hu.stall_fetch          = 1'b1;
                hu.hazard_prog_cntr_sel = PC_HOLD;
                hu.inst_word_sel        = 1'b1;
                if (hu.mem_wb_opcode == RET_OPCODE) begin
                    hu.hazard_prog_cntr_sel = PC_RET;
                    if (hu.mem_wb_reti_bit) begin
                        in_isr_nxt = 1'b0;
                    end
                    state_nxt = RUN;
                end
            end
            HALTED: begin
                hu.stall_fetch          = 1'b1;
                hu.stall_decode         = 1'b1;
                hu.hazard_prog_cntr_sel = PC_HOLD;
                // Wake ignores stall requests: the pipeline is frozen anyway
                if (irq_ok) begin
                    take_irq = 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (take_irq && !reset) begin
            hu.int_ack   = irq_onehot;
            int_addr_nxt = irq_vec;
            state_nxt    = INT_ENTER;
        end
    end

    assign hu.prog_cntr_int_addr = int_addr_q;
    assign hu.in_isr             = in_isr_q;

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block that sits beside the CPU datapath.
- Consumes the decode stage's requests: stall, halt, branch, return, illegal opcode.
- Consumes the MEM/WB opcode and RETI bit, plus external interrupt lines.
- Drives the fetch stall, the decode stall, the program-counter source select, instruction-word injection (NOP or interrupt CALL), and the interrupt vector address. It owns interrupt entry/exit sequencing and the return-address wait.

Parameters:
- NUM_IRQ, 8: number of interrupt lines; index 0 has highest priority.
- VECTOR_BASE, 14'h0004: program address of the IRQ0 vector.
- VECTOR_STRIDE, 2: address distance between consecutive IRQ vectors.
- EXC_VECTOR, 14'h0002: illegal-opcode handler address.
- NOP_WORD, 32'h0000_0000: injected bubble instruction.
- INT_CALL_WORD, 32'h0000_0041: injected call instruction for interrupt entry; pushes the return address.
- RET_OPCODE, 8'h42: opcode of RET/RETI as seen at MEM/WB.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- stall_fetch_req  in  1  from decode.
- stall_decode_req  in  1  from decode.
- halt  in  1  from decode.
- take_branch_target  in  1  from decode.
- illegal_opcode_exception  in  1  from decode.
- return_in_pipeline  in  1  from decode.
- mem_wb_opcode  in  8  MEM/WB opcode.
- mem_wb_reti_bit  in  1  MEM/WB instruction bit 20.
- irq  in  NUM_IRQ  level interrupt requests.
- irq_enable  in  NUM_IRQ  per-line mask, from SFR.
- global_int_en  in  1  from SFR.
- stall_fetch  out  1
- stall_decode  out  1
- hazard_prog_cntr_sel  out  4  0=PC_INC, 1=PC_BRANCH, 2=PC_INT, 3=PC_RET, 4=PC_HOLD.
- inst_word_sel  out  1  1 = IF/ID loads hazard_inst_word.
- hazard_inst_word  out  32
- prog_cntr_int_addr  out  14  registered vector address.
- in_isr  out  1  interrupt service active.
- int_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge.

Behaviour:
- State is registered: RUN, INT_ENTER, EXC_ENTER, RET_WAIT, HALTED.
- Outputs are combinational from state plus current inputs (Mealy). Redirect takes effect in the same cycle.
- Reset values:
  - state RUN, in_isr 0, int_ack 0, prog_cntr_int_addr 0.
  - With idle inputs: stall_fetch 0, stall_decode 0, sel PC_INC, inst_word_sel 0, hazard_inst_word NOP_WORD.
  - Reset asserted in any state returns to RUN and aborts any sequence in progress.
- Defaults in RUN:
  - stall_fetch = stall_fetch_req; stall_decode = stall_decode_req.
  - sel is PC_HOLD if stall_fetch_req, otherwise PC_INC.
- RUN priority when events coincide: illegal_opcode_exception > take_branch_target > return_in_pipeline > halt > interrupt.
- Exception:
  - This cycle: inst_word_sel 1 with NOP_WORD.
  - prog_cntr_int_addr <= EXC_VECTOR; next state EXC_ENTER.
- EXC_ENTER (1 cycle): sel PC_INT, in_isr <= 1, then RUN. Exceptions nest: in_isr is ignored for exceptions.
- Branch: sel PC_BRANCH and inst_word_sel 1 with NOP_WORD (flushes the wrong-path fetch) for exactly that cycle; stay in RUN.
- Return:
  - return_in_pipeline moves the state to RET_WAIT.
  - RET_WAIT drives stall_fetch 1, sel PC_HOLD, and inst_word_sel 1 with NOP_WORD every cycle.
  - When mem_wb_opcode == RET_OPCODE: sel PC_RET in that cycle, in_isr <= 0 if mem_wb_reti_bit, next state RUN.
- Halt: go to HALTED, which drives stall_fetch 1, stall_decode 1, sel PC_HOLD.
- Interrupt eligibility: pending = irq & irq_enable. Entry is taken only when all of the following hold:
  - pending is nonzero and global_int_en = 1;
  - in_isr = 0;
  - state is RUN and no higher-priority event is active;
  - stall_fetch_req = 0 and stall_decode_req = 0.
- Interrupt entry:
  - Select the lowest set index k.
  - prog_cntr_int_addr <= VECTOR_BASE + k*VECTOR_STRIDE (14-bit, wraps modulo 2^14).
  - int_ack[k] pulses 1 cycle; next state INT_ENTER.
- INT_ENTER (1 cycle): inst_word_sel 1 with INT_CALL_WORD, sel PC_INT, in_isr <= 1, then RUN.
- HALTED wake: on a pending enabled interrupt with global_int_en, perform the entry sequence regardless of stall requests. Otherwise remain HALTED indefinitely.
- An interrupt arriving during RET_WAIT stays pending until RUN.
- Level irq deasserting before entry: nothing is taken.

Test Plan:
- Reset, then idle inputs for 5 cycles -> sel 0, stalls 0, inst_word_sel 0, in_isr 0 on every cycle.
- Branch: take_branch_target=1 for 1 cycle -> sel 1 and inst_word_sel 1 with word 0 in that cycle only; sel 0 the next cycle.
- Interrupt entry: irq=8'b0000_0110, irq_enable=8'hFF, global_int_en=1 -> int_ack=8'b0000_0010, then next cycle prog_cntr_int_addr=14'h0006, hazard_inst_word=32'h41, sel 2; in_isr=1 afterwards. irq[3] pulsed while in_isr=1 -> not taken.
- RETI exit: return_in_pipeline=1, then mem_wb_opcode=8'h42 with reti bit 1 three cycles later -> stall_fetch 1 with NOP injected for 3 cycles, sel 3 on the fourth, in_isr 0 after.
- Halt/wake: halt=1 -> both stalls 1 and sel 4 held for 10 cycles; irq[0] enabled -> exit via entry sequence with address 14'h0004.
- Collision and reset: illegal_opcode_exception and take_branch_target asserted together -> exception path with EXC_VECTOR 14'h0002. reset asserted during RET_WAIT -> RUN and in_isr 0 on the next cycle.
